// File: rtl/mcp3202_spi_responder.sv
// mcp3202_spi_responder: MCP3202 ADC slave emulator on an oversampled SPI bus
// Ports:
//   clk, rst_n            system clock (>= 8x SCK), async active-low reset
//   cs, sck, mosi         SPI master signals, asynchronous to clk
//   ch0_code, ch1_code    channel codes, captured at the conversion point
//   miso, miso_oe         slave data and its pad enable (miso=0 when not enabled)
//   cfg                   {SGL,ODD,MSBF} of the last decoded frame
//   conv_valid            1-clk pulse when cfg/code are captured
//   frame_err             1-clk pulse when cs rises before the frame completes
module mcp3202_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        sck,
    input  logic        mosi,
    input  logic [11:0] ch0_code,
    input  logic [11:0] ch1_code,
    output logic        miso,
    output logic        miso_oe,
    output logic [2:0]  cfg,
    output logic        conv_valid,
    output logic        frame_err
);
    typedef enum logic [2:0] {IDLE, WAIT_START, CFG, NULL_BIT, DATA_MSB, DATA_LSB, TAIL} state_t;
    state_t state;
    // cs and sck chains carry one extra flop holding the previous synced value for edge detection
    logic [SYNC_STAGES:0]   cs_q, sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic        cs_rise, cs_fall, sck_rise, sck_fall, mosi_s;
    logic [1:0]  cfg_shift, bit_cnt;
    logic [3:0]  bit_idx;
    logic [11:0] code, code_sel;
    logic [12:0] d01, d10;
    assign cs_rise  =  cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
    assign cs_fall  = ~cs_q[SYNC_STAGES-1] &  cs_q[SYNC_STAGES];
    assign sck_rise =  sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
    assign sck_fall = ~sck_q[SYNC_STAGES-1] &  sck_q[SYNC_STAGES];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    // 13-bit differences: bit 12 set means the result went negative and clamps to zero
    assign d01 = {1'b0, ch0_code} - {1'b0, ch1_code};
    assign d10 = {1'b0, ch1_code} - {1'b0, ch0_code};
    // cfg_shift holds {SGL,ODD} at the moment MSBF is being sampled
    assign code_sel = cfg_shift[1] ? (cfg_shift[0] ? ch1_code : ch0_code) :
                      cfg_shift[0] ? (d10[12] ? 12'h000 : d10[11:0]) :
                                     (d01[12] ? 12'h000 : d01[11:0]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= '1;
            sck_q  <= '0;
            mosi_q <= '0;
        end else begin
            cs_q   <= {cs_q[SYNC_STAGES-1:0], cs};
            sck_q  <= {sck_q[SYNC_STAGES-1:0], sck};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            cfg        <= 3'b000;
            conv_valid <= 1'b0;
            frame_err  <= 1'b0;
            cfg_shift  <= '0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            code       <= '0;
        end else begin
            conv_valid <= 1'b0;
            frame_err  <= 1'b0;
            // cs rise overrides any simultaneous sck edge
            if (cs_rise) begin
                frame_err <= state inside {CFG, NULL_BIT, DATA_MSB, DATA_LSB};
                state     <= IDLE;
                miso      <= 1'b0;
                miso_oe   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state     <= WAIT_START;
                        miso_oe   <= 1'b1;
                        miso      <= 1'b0;
                        cfg_shift <= '0;
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                    end
                    WAIT_START: if (sck_rise && mosi_s) begin
                        state   <= CFG;
                        bit_cnt <= '0;
                    end
                    CFG: if (sck_rise) begin
                        cfg_shift <= {cfg_shift[0], mosi_s};
                        bit_cnt   <= bit_cnt + 2'd1;
                        if (bit_cnt == 2'd2) begin
                            cfg        <= {cfg_shift, mosi_s};
                            code       <= code_sel;
                            conv_valid <= 1'b1;
                            state      <= NULL_BIT;
                        end
                    end
                    NULL_BIT: if (sck_fall) begin
                        miso    <= 1'b0;
                        state   <= DATA_MSB;
                        bit_idx <= 4'd11;
                    end
                    DATA_MSB: if (sck_fall) begin
                        miso <= code[bit_idx];
                        if (bit_idx == 4'd0) begin
                            state   <= cfg[0] ? TAIL : DATA_LSB;
                            bit_idx <= 4'd1;
                        end else begin
                            bit_idx <= bit_idx - 4'd1;
                        end
                    end
                    DATA_LSB: if (sck_fall) begin
                        miso <= code[bit_idx];
                        if (bit_idx == 4'd11) state <= TAIL;
                        else bit_idx <= bit_idx + 4'd1;
                    end
                    TAIL: if (sck_fall) miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
